// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings (must match the execute-stage source muxes), the mul/div tracker
// state type and the forwarding priority helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Execute-stage forwarding select: M beats W, $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       reg_write_m,
                                         input logic [4:0] write_reg_m,
                                         input logic       reg_write_w,
                                         input logic [4:0] write_reg_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if ((src != 5'd0) && reg_write_m && (write_reg_m == src)) begin
      sel = FWD_MEM;
    end else if ((src != 5'd0) && reg_write_w && (write_reg_w == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/muldiv_busy_tracker.sv
// Occupancy tracker for the multi-cycle mul/div unit. A start loads the
// counter with MULDIV_CYCLES; busy stays high until the count runs out.
// A start while busy reloads the counter (normally prevented upstream).
module muldiv_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic busy_o
);

  localparam int CW = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; leaves BUSY in the cycle the count is 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = MD_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      MD_BUSY: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = MD_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = MD_BUSY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage CPU: execute-stage forwarding
// selects, load-use / mul-div stalls and a shadow copy of the M/W destination
// fields. Optional decode-stage branch forwarding is enabled by defining
// HAZARD_BRANCH_FWD_EN; without it ForwardAD/ForwardBD are 0 and branches
// never stall here.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       MulDivD,
  input  logic       BranchD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       StartMulDivE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       MulDivBusy
);

  logic [4:0] write_reg_m_q, write_reg_w_q;
  logic       reg_write_m_q, reg_write_w_q;
  logic       memto_reg_m_q;
  logic       md_busy_s;
  logic       lwstall_s, mdstall_s, branchstall_s, stall_s;
  logic       fwd_ad_s, fwd_bd_s;

  muldiv_busy_tracker #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_md_tracker (
    .clk    (clk),
    .reset  (reset),
    .start_i(StartMulDivE),
    .busy_o (md_busy_s)
  );

`ifndef HAZARD_BRANCH_FWD_EN
  logic unused_branch_s;
  assign unused_branch_s = &{1'b0, BranchD, memto_reg_m_q};
`endif

  // Shadow of the M/W destination fields; these stages never stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg_m_q <= 5'd0;
      reg_write_m_q <= 1'b0;
      memto_reg_m_q <= 1'b0;
      write_reg_w_q <= 5'd0;
      reg_write_w_q <= 1'b0;
    end else begin
      write_reg_m_q <= WriteRegE;
      reg_write_m_q <= RegWriteE;
      memto_reg_m_q <= MemtoRegE;
      write_reg_w_q <= write_reg_m_q;
      reg_write_w_q <= reg_write_m_q;
    end
  end

  // Stall conditions and decode-stage branch forwarding.
  always_comb begin
    lwstall_s = RegWriteE && MemtoRegE && (WriteRegE != 5'd0) &&
                ((WriteRegE == RsD) || (WriteRegE == RtD));
    mdstall_s = MulDivD && (md_busy_s || StartMulDivE);
`ifdef HAZARD_BRANCH_FWD_EN
    fwd_ad_s = (RsD != 5'd0) && reg_write_m_q && (write_reg_m_q == RsD);
    fwd_bd_s = (RtD != 5'd0) && reg_write_m_q && (write_reg_m_q == RtD);
    branchstall_s = BranchD &&
        ((RegWriteE && (WriteRegE != 5'd0) &&
          ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
         (memto_reg_m_q && (write_reg_m_q != 5'd0) &&
          ((write_reg_m_q == RsD) || (write_reg_m_q == RtD))));
`else
    fwd_ad_s      = 1'b0;
    fwd_bd_s      = 1'b0;
    branchstall_s = 1'b0;
`endif
    stall_s = lwstall_s || mdstall_s || branchstall_s;
  end

  // Output drive; everything is held at 0 while reset is asserted.
  always_comb begin
    ForwardAE  = FWD_RF;
    ForwardBE  = FWD_RF;
    ForwardAD  = 1'b0;
    ForwardBD  = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushE     = 1'b0;
    MulDivBusy = 1'b0;
    if (reset) begin
      ForwardAE  = FWD_RF;
      ForwardBE  = FWD_RF;
    end else begin
      ForwardAE  = fwd_sel(RsE, reg_write_m_q, write_reg_m_q, reg_write_w_q, write_reg_w_q);
      ForwardBE  = fwd_sel(RtE, reg_write_m_q, write_reg_m_q, reg_write_w_q, write_reg_w_q);
      ForwardAD  = fwd_ad_s;
      ForwardBD  = fwd_bd_s;
      StallF     = stall_s;
      StallD     = stall_s;
      FlushE     = stall_s;
      MulDivBusy = md_busy_s;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MULDIV_CYCLES = 4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the edge, well before the next one.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE;
  logic       MulDivD, BranchD, RegWriteE, MemtoRegE, StartMulDivE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MulDivBusy;

  int tests = 0;
  int fails = 0;

  hazard_unit #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .MulDivD(MulDivD), .BranchD(BranchD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .StartMulDivE(StartMulDivE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MulDivBusy(MulDivBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    RsD = 5'd0; RtD = 5'd0; MulDivD = 1'b0; BranchD = 1'b0;
    RsE = 5'd0; RtE = 5'd0; WriteRegE = 5'd0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; StartMulDivE = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, "_F"}, 8'(StallF), 8'(exp));
    check({tag, "_D"}, 8'(StallD), 8'(exp));
    check({tag, "_E"}, 8'(FlushE), 8'(exp));
  endtask

  logic exp_br;

  initial begin
`ifdef HAZARD_BRANCH_FWD_EN
    exp_br = 1'b1;
`else
    exp_br = 1'b0;
`endif
    // Reset: outputs held at 0 even with a load-use pattern on the inputs.
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2;
    settle();
    check_stall("rst_stall", 1'b0);
    check("rst_busy", 8'(MulDivBusy), 8'd0);
    check("rst_fae", 8'(ForwardAE), 8'd0);
    tick();
    clear_inputs();
    reset = 1'b0;

    // Load-use: lw $2 in E, consumer in D.
    tick();
    RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2;
    settle();
    check_stall("lw_stall", 1'b1);
    tick();
    // Bubble in E, consumer still in D.
    RegWriteE = 1'b0; MemtoRegE = 1'b0; WriteRegE = 5'd0;
    settle();
    check_stall("lw_release", 1'b0);
    tick();
    // Consumer in E; lw now in W.
    RsD = 5'd0; RsE = 5'd2;
    settle();
    check("lw_fae_wb", 8'(ForwardAE), 8'd1);

    // M/W both writing $5: M wins.
    tick();
    clear_inputs();
    RegWriteE = 1'b1; WriteRegE = 5'd5;
    tick();
    tick();
    RsE = 5'd5; RtE = 5'd5; RegWriteE = 1'b1; WriteRegE = 5'd0;
    settle();
    check("prio_fae_mem", 8'(ForwardAE), 8'd2);
    check("prio_fbe_mem", 8'(ForwardBE), 8'd2);
    tick();
    // M writes $0, W writes $5: RsE=0 never forwards.
    RsE = 5'd0; RtE = 5'd5; RegWriteE = 1'b0;
    settle();
    check("zero_fae", 8'(ForwardAE), 8'd0);
    check("w_fbe", 8'(ForwardBE), 8'd1);

    // W writes $7, M holds $7 but not writing.
    tick();
    clear_inputs();
    RegWriteE = 1'b1; WriteRegE = 5'd7;
    tick();
    RegWriteE = 1'b0; WriteRegE = 5'd7;
    tick();
    clear_inputs();
    RtE = 5'd7; RsE = 5'd7;
    settle();
    check("wb_fbe", 8'(ForwardBE), 8'd1);
    check("wb_fae", 8'(ForwardAE), 8'd1);
    RsE = 5'd3;
    settle();
    check("nomatch_fae", 8'(ForwardAE), 8'd0);

    // Mul/div: start at t with mflo waiting in D.
    tick();
    clear_inputs();
    tick();
    StartMulDivE = 1'b1; MulDivD = 1'b1;
    settle();
    check_stall("md_t", 1'b1);
    check("md_t_busy", 8'(MulDivBusy), 8'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      StartMulDivE = 1'b0;
      settle();
      check_stall($sformatf("md_t%0d", i), 1'b1);
      check($sformatf("md_t%0d_busy", i), 8'(MulDivBusy), 8'd1);
    end
    tick();
    settle();
    check_stall("md_t5", 1'b0);
    check("md_t5_busy", 8'(MulDivBusy), 8'd0);

    // Reset at t+2 abandons the operation.
    tick();
    clear_inputs();
    tick();
    StartMulDivE = 1'b1; MulDivD = 1'b1;
    tick();
    StartMulDivE = 1'b0;
    settle();
    check("mdr_t1_busy", 8'(MulDivBusy), 8'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("mdr_t3_busy", 8'(MulDivBusy), 8'd0);
    check_stall("mdr_t3", 1'b0);
    tick();
    settle();
    check("mdr_t4_busy", 8'(MulDivBusy), 8'd0);
    check_stall("mdr_t4", 1'b0);

    // Branch in D reading $3 while add $3 is in E.
    tick();
    clear_inputs();
    tick();
    BranchD = 1'b1; RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3;
    settle();
    check_stall("br_stall", exp_br);
    check("br_fad0", 8'(ForwardAD), 8'd0);
    tick();
    RegWriteE = 1'b0; WriteRegE = 5'd0;
    settle();
    check_stall("br_release", 1'b0);
    check("br_fad1", 8'(ForwardAD), 8'(exp_br));
    check("br_fbd1", 8'(ForwardBD), 8'd0);

    tick();
    clear_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
